// File: rtl/num_gen_pkg.sv
// Shared constants for the guessing-game number source: widths, default seed
// and the game's value range, also used by the game controller.
package num_gen_pkg;

  localparam int LFSR_W = 16;
  localparam int OUT_W  = 7;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  localparam int DEFAULT_MIN_VAL = 1;
  localparam int DEFAULT_MAX_VAL = 100;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, with seed load on reset and
// a guard that reloads the seed if the state ever becomes all-zero.
module lfsr16
  import num_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_ni,
  output logic [LFSR_W-1:0] state_o,
  output logic [LFSR_W-1:0] next_state_o
);

  localparam logic [LFSR_W-1:0] SEED_EFF = fix_seed(SEED);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;
  logic              fb;

  assign fb = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];

  always_comb begin
    state_d = {state_q[LFSR_W-2:0], fb};
    if (state_q == '0) begin
      state_d = SEED_EFF;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o      = state_q;
  assign next_state_o = state_d;

endmodule

// File: rtl/num_generator.sv
// Pseudo-random secret-number source: the low LFSR bits are range-reduced by
// rejection into a registered value in MIN_VAL..MAX_VAL.
module num_generator
  import num_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED,
  parameter int                MIN_VAL = DEFAULT_MIN_VAL,
  parameter int                MAX_VAL = DEFAULT_MAX_VAL
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] generated_number
);

  localparam logic [OUT_W-1:0] SPAN_C    = OUT_W'(MAX_VAL - MIN_VAL);
  localparam logic [OUT_W:0]   MIN_C     = (OUT_W + 1)'(MIN_VAL);
  localparam logic [OUT_W-1:0] RST_VAL_C = OUT_W'(MIN_VAL);

  logic [LFSR_W-1:0] lfsr_state;
  logic [LFSR_W-1:0] lfsr_next;
  logic [OUT_W-1:0]  cand;
  logic [OUT_W:0]    sum;
  logic [OUT_W-1:0]  gen_q;
  logic [OUT_W-1:0]  gen_d;
  logic              unused_bits;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk         (clk),
    .rst_ni      (reset),
    .state_o     (lfsr_state),
    .next_state_o(lfsr_next)
  );

  // Candidate comes from the value the LFSR is about to take, so the output
  // updates on the same edge as the LFSR step.
  assign cand = lfsr_next[OUT_W-1:0];
  assign sum  = {1'b0, cand} + MIN_C;

  always_comb begin
    gen_d = gen_q;
    if (cand <= SPAN_C) begin
      gen_d = sum[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen_q <= RST_VAL_C;
    end else begin
      gen_q <= gen_d;
    end
  end

  assign generated_number = gen_q;
  assign unused_bits      = ^{lfsr_state, lfsr_next[LFSR_W-1:OUT_W]};

endmodule

// File: tb/tb_num_generator.sv
// Directed self-checking bench for num_generator with a small reference
// model of the LFSR and the rejection-based range reduction.
`timescale 1ns/1ps
module tb_num_generator;

  logic       clk;
  logic       reset;
  logic [6:0] generated_number;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_state;
  logic [6:0]  m_out;
  logic [6:0]  m_prev_out;
  logic [15:0] m_prev_state;

  num_generator dut (
    .clk             (clk),
    .reset           (reset),
    .generated_number(generated_number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_next(input logic [15:0] s);
    if (s == 16'h0000) return 16'hACE1;
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Advance one clock and the model alongside; sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    m_prev_out   = m_out;
    m_prev_state = m_state;
    m_state      = model_next(m_state);
    if (m_state[6:0] <= 7'd99) m_out = m_state[6:0] + 7'd1;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    #20;
    m_state = 16'hACE1;
    m_out   = 7'd1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #20;
    checks++;
    if (generated_number !== 7'd1) begin
      errors++;
      $display("FAIL reset_value: got %0d expected 1", generated_number);
    end
    checks++;
    if (dut.u_lfsr.state_q !== 16'hACE1) begin
      errors++;
      $display("FAIL reset_seed: got %h expected ace1", dut.u_lfsr.state_q);
    end
    m_state = 16'hACE1;
    m_out   = 7'd1;
    @(negedge clk);
    reset = 1'b1;
    $display("test_reset: output=%0d state=%h", generated_number, dut.u_lfsr.state_q);
  endtask

  task automatic test_known_sequence();
    logic [6:0] hand_exp [2];
    hand_exp[0] = 7'd68;
    hand_exp[1] = 7'd8;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (generated_number !== hand_exp[i]) begin
        errors++;
        $display("FAIL known_seq[%0d]: got %0d expected %0d", i, generated_number, hand_exp[i]);
      end
    end
    checks++;
    if (dut.u_lfsr.state_q !== 16'hB387) begin
      errors++;
      $display("FAIL known_state: got %h expected b387", dut.u_lfsr.state_q);
    end
    for (int i = 2; i < 40; i++) begin
      step();
      checks++;
      if (generated_number !== m_out) begin
        errors++;
        $display("FAIL model_seq[%0d]: got %0d expected %0d", i, generated_number, m_out);
      end
    end
    $display("test_known_sequence: 40 edges, last output=%0d", generated_number);
  endtask

  task automatic test_rejection_hold();
    bit found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      step();
      if (m_state[6:0] >= 7'd100) begin
        found = 1;
        checks++;
        if (generated_number !== m_prev_out) begin
          errors++;
          $display("FAIL reject_hold: got %0d expected %0d (cand=%0d)", generated_number, m_prev_out, m_state[6:0]);
        end
        checks++;
        if (dut.u_lfsr.state_q !== m_state || m_state == m_prev_state) begin
          errors++;
          $display("FAIL reject_advance: got %h expected %h", dut.u_lfsr.state_q, m_state);
        end
        $display("test_rejection_hold: cand=%0d held output=%0d", m_state[6:0], generated_number);
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL reject_search: got none expected a rejected candidate within 500 cycles");
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (generated_number !== 7'd1) begin
      errors++;
      $display("FAIL async_reset: got %0d expected 1", generated_number);
    end
    #20;
    m_state = 16'hACE1;
    m_out   = 7'd1;
    @(negedge clk);
    reset = 1'b1;
    $display("test_async_reset: output=%0d during mid-cycle reset", 7'd1);
  endtask

  task automatic test_mid_run_reset();
    logic [6:0] hand_exp [2];
    hand_exp[0] = 7'd68;
    hand_exp[1] = 7'd8;
    for (int i = 0; i < 10; i++) step();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (generated_number !== hand_exp[i]) begin
        errors++;
        $display("FAIL midrun_seq[%0d]: got %0d expected %0d", i, generated_number, hand_exp[i]);
      end
    end
    $display("test_mid_run_reset: restarted with 68, 8");
  endtask

  task automatic test_lockup_guard();
    @(negedge clk);
    force dut.u_lfsr.state_q = 16'h0000;
    #1;
    release dut.u_lfsr.state_q;
    m_state = 16'h0000;
    step();
    checks++;
    if (dut.u_lfsr.state_q !== 16'hACE1) begin
      errors++;
      $display("FAIL lockup_state: got %h expected ace1", dut.u_lfsr.state_q);
    end
    // Seed low bits are 0x61 = 97, accepted, giving 98.
    checks++;
    if (generated_number !== 7'd98) begin
      errors++;
      $display("FAIL lockup_out: got %0d expected 98", generated_number);
    end
    step();
    checks++;
    if (generated_number !== 7'd68) begin
      errors++;
      $display("FAIL lockup_resume: got %0d expected 68", generated_number);
    end
    $display("test_lockup_guard: reloaded seed, resumed at %0d", generated_number);
  endtask

  task automatic test_range();
    bit seen [128];
    int missing = 0;
    int bad = 0;
    for (int v = 0; v < 128; v++) seen[v] = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      seen[generated_number] = 1;
      if (generated_number < 7'd1 || generated_number > 7'd100 || generated_number !== m_out) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL range_samples: got %0d bad samples expected 0", bad);
    end
    for (int v = 1; v <= 100; v++) if (!seen[v]) missing++;
    checks++;
    if (missing != 0) begin
      errors++;
      $display("FAIL range_coverage: got %0d missing values expected 0", missing);
    end
    checks++;
    if (seen[0] || seen[101] || seen[127]) begin
      errors++;
      $display("FAIL range_outside: got out-of-range value expected none");
    end
    $display("test_range: 10000 samples, %0d bad, %0d values missing", bad, missing);
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_known_sequence();
    test_rejection_hold();
    test_async_reset();
    test_mid_run_reset();
    test_lockup_guard();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/num_generator.md
# num_generator

Pseudo-random target-number source for the up/down guessing game. A free-running 16-bit LFSR advances on every clock. Its low bits are range-reduced by rejection into a registered 7-bit value in 1..100, which the game-control logic samples as the secret number. The block has no handshake: consumers capture `generated_number` whenever a new game starts.

## Interface
Parameters:
- `SEED`, default 16'hACE1: LFSR reset state. A value of 0 is replaced by 16'h0001.
- `MIN_VAL`, default 1: lowest output value.
- `MAX_VAL`, default 100: highest output value. Requires MAX_VAL − MIN_VAL ≤ 127 and MAX_VAL ≤ 127.

Ports:
- `clk`  input  1  sole clock, rising-edge.
- `reset`  input  1  asynchronous, active-low reset. Asserted when 0; sequential state is cleared immediately, independent of `clk`.
- `generated_number`  output  7  current random value, always within MIN_VAL..MAX_VAL (unsigned).

## Operation
- **LFSR:** 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1 (maximal length, period 65535).
  - Feedback: fb = s[15]^s[13]^s[12]^s[10].
  - Next state: next = {s[14:0], fb}.
- **Lock-up guard:** if the state is ever all-zero, the next state is SEED (or 16'h0001 if SEED is 0).
- **Candidate:** cand = next[6:0], evaluated in the same cycle as the LFSR update.
- **Range reduction (rejection):**
  - If cand ≤ MAX_VAL − MIN_VAL, then `generated_number` ← cand + MIN_VAL.
  - Otherwise `generated_number` holds its previous value.
  - No modulo operation is used.
- **Arithmetic:** cand + MIN_VAL is computed at 8 bits and truncated to 7 bits. The parameter constraint guarantees no overflow.
- **Reset:** LFSR ← SEED and `generated_number` ← MIN_VAL (7'd1 with defaults). The output is never 0 or greater than 100 with defaults, including during reset.
- **Reset mid-run:** restarts the exact same sequence from SEED. The sequence is deterministic and repeatable after every reset.

## Timing
- One LFSR step per rising edge of `clk` while `reset` = 1.
- Output is registered. A new value appears on the same edge that advances the LFSR, so latency from LFSR state to output is 0 extra cycles.
- First edge after reset release (defaults): LFSR 16'hACE1 → 16'h59C3, cand = 67, output = 68.
- Second edge: LFSR → 16'hB387, cand = 7, output = 8.
- A rejected candidate (cand ≥ 100) holds the output for that cycle. At most about 22% of cycles are rejected on average.
- Reset assertion takes effect asynchronously. Deassertion is assumed to be synchronised upstream to `clk`.
- No combinational path from `reset` to the output other than the flop's asynchronous clear/set.

## Structure
- Shared package `num_gen_pkg` holds:
  - `LFSR_W` = 16
  - `OUT_W` = 7
  - default SEED
  - default MIN_VAL and MAX_VAL (game range 1..100), shared with the game controller.
- One sub-module, `lfsr16`, contains the state register, feedback, lock-up guard and seed load. It exposes `state` and `next_state`.
- The top level performs candidate extraction, the range compare and the output register.

## Test plan
- **Reset value:** hold `reset` = 0 for 20 ns → `generated_number` = 1. Also check that asserting `reset` between clock edges clears the output immediately.
- **Known sequence:** release `reset` → on successive edges the outputs are 68, then 8, continuing per the reference model of the polynomial above.
- **Range:** run 10,000 cycles → every sample is in 1..100. All 100 values occur at least once, and no value outside the range ever occurs.
- **Rejection hold:** force or identify a cycle where cand ≥ 100 → the output equals the previous cycle's value, and the LFSR still advances.
- **Mid-run reset:** run 10 cycles, assert `reset` for 20 ns, then release → the output sequence restarts at 68, 8, … identical to the first run.
- **Lock-up guard:** force the LFSR state to 0 → the next edge loads SEED (16'hACE1) and the sequence resumes.
